// File: rtl/decode_pkg.sv
// Shared opcode constants and source-usage encoding for the decode stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic [1:0] {
    NONE,
    RS,
    RS_RT
  } src_use_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with a hazard query that
// already sees a writeback retiring in the current cycle.
module reg_scoreboard
  import decode_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  src_use_t          uses,
  output logic              hazard
);

  localparam int unsigned NRegs = 1 << ADDR_W;

  logic [NRegs-1:0] busy_q, busy_d, eff_busy, wb_mask, set_mask;

  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_valid) wb_mask[wb_reg] = 1'b1;
    if (set_en)   set_mask[set_reg] = 1'b1;
    eff_busy = busy_q & ~wb_mask;
    // Applying the set after the clear lets a same-cycle issue win.
    busy_d    = eff_busy | set_mask;
    busy_d[0] = 1'b0;
  end

  // rd is 0 for non-writing instructions, and register 0 is never busy.
  always_comb begin
    hazard = eff_busy[rd];
    if (uses != NONE && eff_busy[rs]) hazard = 1'b1;
    if (uses == RS_RT && eff_busy[rt]) hazard = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// One-entry decode stage: holds an instruction, decodes register-file fields and
// the immediate, and issues once the scoreboard reports no RAW/WAW hazard.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] readreg1,
  output logic [ADDR_W-1:0] readreg2,
  output logic [ADDR_W-1:0] writereg,
  output logic              regwrite,
  output logic [DATA_W-1:0] imm_ext,
  output logic              illegal,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg
);

  logic              full_q;
  logic [DATA_W-1:0] instr_q;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0] imm_sext, imm_zext;
  src_use_t          uses;
  logic              wr_en, hazard, issue, accept;

  assign opcode   = instr_q[31:26];
  assign rs       = ADDR_W'(instr_q[25:21]);
  assign rt       = ADDR_W'(instr_q[20:16]);
  assign rd       = ADDR_W'(instr_q[15:11]);
  assign imm_sext = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
  assign imm_zext = {{(DATA_W-16){1'b0}}, instr_q[15:0]};

  always_comb begin
    uses     = NONE;
    writereg = '0;
    wr_en    = 1'b0;
    imm_ext  = '0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses     = RS_RT;
        writereg = rd;
        wr_en    = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        uses     = RS;
        writereg = rt;
        wr_en    = 1'b1;
        imm_ext  = imm_sext;
      end
      OP_ANDI, OP_ORI: begin
        uses     = RS;
        writereg = rt;
        wr_en    = 1'b1;
        imm_ext  = imm_zext;
      end
      OP_SW, OP_BEQ: begin
        uses    = RS_RT;
        imm_ext = imm_sext;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign readreg1 = (uses != NONE)  ? rs : '0;
  assign readreg2 = (uses == RS_RT) ? rt : '0;
  assign regwrite = wr_en && (writereg != '0);

  assign out_valid = full_q && !hazard && !clr;
  assign issue     = out_valid && out_ready;
  assign in_ready  = !clr && (!full_q || issue);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      full_q  <= 1'b0;
      instr_q <= '0;
    end else if (accept) begin
      full_q  <= 1'b1;
      instr_q <= instr;
    end else if (issue) begin
      full_q  <= 1'b0;
    end
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .clr      (clr),
    .set_en   (issue && regwrite),
    .set_reg  (writereg),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .rs       (readreg1),
    .rt       (readreg2),
    .rd       (writereg),
    .uses     (uses),
    .hazard   (hazard)
  );

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed and randomized checks of instr_decode_stage against a behavioural model.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        clr, in_valid, in_ready, out_valid, out_ready;
  logic        regwrite, illegal, wb_valid;
  logic [31:0] instr, imm_ext;
  logic [4:0]  readreg1, readreg2, writereg, wb_reg;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_busy[32];
  bit          m_full;
  logic [31:0] m_instr;
  bit          obs_accept;

  always #5 clk = ~clk;

  instr_decode_stage #(
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .readreg1  (readreg1),
    .readreg2  (readreg2),
    .writereg  (writereg),
    .regwrite  (regwrite),
    .imm_ext   (imm_ext),
    .illegal   (illegal),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg)
  );

  typedef struct {
    int          r1, r2, wr;
    bit          we, ill, use1, use2;
    logic [31:0] imm;
  } dec_t;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    int op, rs, rt, rd, lo;
    logic [31:0] sx;
    op = int'(w >> 26);
    rs = int'((w >> 21) % 32);
    rt = int'((w >> 16) % 32);
    rd = int'((w >> 11) % 32);
    lo = int'(w % 65536);
    sx = (lo >= 32768) ? 32'(lo) + 32'hFFFF0000 : 32'(lo);
    d.use1 = 0; d.use2 = 0; d.wr = 0; d.imm = 0; d.ill = 0; d.we = 0;
    case (op)
      'h00:       begin d.use1 = 1; d.use2 = 1; d.wr = rd; d.we = 1; end
      'h08, 'h23: begin d.use1 = 1; d.wr = rt; d.we = 1; d.imm = sx; end
      'h0C, 'h0D: begin d.use1 = 1; d.wr = rt; d.we = 1; d.imm = 32'(lo); end
      'h2B, 'h04: begin d.use1 = 1; d.use2 = 1; d.imm = sx; end
      default:    d.ill = 1;
    endcase
    d.r1 = d.use1 ? rs : 0;
    d.r2 = d.use2 ? rt : 0;
    d.we = d.we && (d.wr != 0);
    return d;
  endfunction

  function automatic bit eff_busy(input int r);
    return (r != 0) && m_busy[r] && !(wb_valid && int'(wb_reg) == r);
  endfunction

  function automatic bit m_hazard(input dec_t d);
    return (d.use1 && eff_busy(d.r1)) || (d.use2 && eff_busy(d.r2)) || (d.we && eff_busy(d.wr));
  endfunction

  // Compare every output mid-cycle, then advance the model across the next edge.
  task automatic tick();
    dec_t d;
    bit   exp_ov, exp_ir, iss, acc;
    @(negedge clk);
    d      = ref_decode(m_instr);
    exp_ov = m_full && !m_hazard(d) && !clr;
    exp_ir = !clr && (!m_full || (exp_ov && out_ready));
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    check_eq("in_ready",  32'(in_ready),  32'(exp_ir));
    check_eq("readreg1",  32'(readreg1),  32'(d.r1));
    check_eq("readreg2",  32'(readreg2),  32'(d.r2));
    check_eq("writereg",  32'(writereg),  32'(d.wr));
    check_eq("regwrite",  32'(regwrite),  32'(d.we));
    check_eq("imm_ext",   imm_ext,        d.imm);
    check_eq("illegal",   32'(illegal),   32'(d.ill));
    obs_accept = in_valid && in_ready;
    iss = exp_ov && out_ready;
    acc = in_valid && exp_ir;
    if (clr) begin
      m_full  = 0;
      m_instr = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      if (wb_valid)     m_busy[wb_reg] = 0;
      if (iss && d.we)  m_busy[d.wr] = 1;
      if (acc)          begin m_full = 1; m_instr = instr; end
      else if (iss)     m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    clr = 1; in_valid = 0; wb_valid = 0;
    tick();
    clr = 0;
  endtask

  // Present an instruction until the DUT takes it; returns in the cycle after acceptance.
  task automatic send(input logic [31:0] w);
    in_valid = 1;
    instr    = w;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (obs_accept) break;
    end
    check_eq("send_accept", 32'(obs_accept), 32'd1);
    in_valid = 0;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  op;
    w = $urandom;
    case ($urandom % 9)
      0: op = 6'h00;  1: op = 6'h08;  2: op = 6'h23;
      3: op = 6'h0C;  4: op = 6'h0D;  5: op = 6'h2B;
      6: op = 6'h04;  7: op = 6'h3F;  default: op = 6'h11;
    endcase
    w[31:26] = op;
    w[25:21] = 5'($urandom % 8);
    w[20:16] = 5'($urandom % 8);
    if (op == 6'h00) w[15:11] = 5'($urandom % 8);
    return w;
  endfunction

  initial begin
    clr = 1; in_valid = 0; out_ready = 1; wb_valid = 0; wb_reg = 0; instr = 0;
    @(posedge clk);
    #1;
    m_full = 0; m_instr = 0;
    foreach (m_busy[i]) m_busy[i] = 0;

    // Reset held two cycles with an instruction offered
    in_valid = 1; instr = 32'h014B4820;
    tick();
    tick();
    check_eq("busy_reset", dut.u_scoreboard.busy_q, 32'd0);
    clr = 0; in_valid = 0;
    #1;
    check_eq("in_ready_after_clr", 32'(in_ready), 32'd1);

    // R-type decode
    send(32'h014B4820);
    check_eq("rtype_rr1", 32'(readreg1), 32'd10);
    check_eq("rtype_rr2", 32'(readreg2), 32'd11);
    check_eq("rtype_wr",  32'(writereg), 32'd9);
    check_eq("rtype_we",  32'(regwrite), 32'd1);
    check_eq("rtype_ov",  32'(out_valid), 32'd1);
    tick();

    // Extensions
    reset_dut();
    send(32'h2128FFFF);
    check_eq("addi_imm", imm_ext, 32'hFFFFFFFF);
    check_eq("addi_wr",  32'(writereg), 32'd8);
    tick();
    reset_dut();
    send(32'h3528FFFF);
    check_eq("ori_imm", imm_ext, 32'h0000FFFF);
    tick();

    // RAW stall, released by a same-cycle writeback
    reset_dut();
    send(32'h8C080004);
    check_eq("lw_ov", 32'(out_valid), 32'd1);
    send(32'h01084820);
    check_eq("raw_ov_stall", 32'(out_valid), 32'd0);
    check_eq("raw_ir_stall", 32'(in_ready),  32'd0);
    tick();
    tick();
    wb_valid = 1; wb_reg = 8;
    #1;
    check_eq("raw_release", 32'(out_valid), 32'd1);
    tick();
    wb_valid = 0;

    // Issue and writeback on the same register: set wins
    reset_dut();
    send(32'h20050007);
    wb_valid = 1; wb_reg = 5;
    tick();
    wb_valid = 0;
    check_eq("busy5_set", 32'(dut.u_scoreboard.busy_q[5]), 32'd1);
    send(32'h00A03020);
    check_eq("busy5_stall", 32'(out_valid), 32'd0);
    wb_valid = 1; wb_reg = 5;
    tick();
    wb_valid = 0;

    // $zero destination and readers
    reset_dut();
    send(32'h00220020);
    check_eq("zero_we", 32'(regwrite), 32'd0);
    tick();
    send(32'h00001820);
    check_eq("zero_reader", 32'(out_valid), 32'd1);
    tick();

    // Illegal opcode issues despite busy sources
    reset_dut();
    send(32'h8C080004);
    tick();
    send(32'hFD080000);
    check_eq("ill_flag", 32'(illegal),  32'd1);
    check_eq("ill_we",   32'(regwrite), 32'd0);
    check_eq("ill_ov",   32'(out_valid), 32'd1);
    tick();

    // Randomized traffic
    reset_dut();
    obs_accept = 1;
    for (int n = 0; n < 1500; n++) begin
      int r;
      clr       = ($urandom % 100) == 0;
      out_ready = ($urandom % 4) != 0;
      if (!in_valid || obs_accept) begin
        in_valid = ($urandom % 3) != 0;
        instr    = rand_instr();
      end
      r        = int'($urandom % 8);
      wb_reg   = 5'(r);
      wb_valid = (m_busy[r] && ($urandom % 2 == 0)) || ($urandom % 8 == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

- Pipeline stage directly upstream of `memory_register`.
- Accepts 32-bit MIPS-subset instructions over a valid/ready handshake and holds each one in a one-entry stage register.
- Decodes the `readreg1`, `readreg2`, `writereg` and `regwrite` fields that drive the register file, plus a sign/zero-extended immediate.
- A 32-entry pending-write scoreboard stalls issue on RAW/WAW hazards until writeback releases the destination register.

## Interface
Parameters:
- `ADDR_W`, 5: register address width (32 registers)
- `DATA_W`, 32: instruction and immediate width

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `clr`  input  1  reset, synchronous, active-high
- `in_valid`  input  1  upstream instruction valid
- `in_ready`  output  1  stage can accept this cycle
- `instr`  input  DATA_W  instruction word
- `out_valid`  output  1  decoded instruction issuable
- `out_ready`  input  1  downstream accepts
- `readreg1`  output  ADDR_W  source 1 (rs)
- `readreg2`  output  ADDR_W  source 2 (rt)
- `writereg`  output  ADDR_W  destination
- `regwrite`  output  1  instruction writes a register
- `imm_ext`  output  DATA_W  extended immediate
- `illegal`  output  1  unsupported opcode
- `wb_valid`  input  1  writeback retiring a write
- `wb_reg`  input  ADDR_W  register being retired

## Operation
- Opcode is `instr[31:26]`; rs is `[25:21]`, rt is `[20:16]`, rd is `[15:11]`.
- Opcode 0x00, R-type: read rs and rt; write rd.
- Opcodes 0x08 (addi) and 0x23 (lw): read rs; write rt; `imm_ext` is the sign-extended `instr[15:0]`.
- Opcodes 0x0C (andi) and 0x0D (ori): read rs; write rt; `imm_ext` is the zero-extended `instr[15:0]`.
- Opcodes 0x2B (sw) and 0x04 (beq): read rs and rt; no write; `imm_ext` is sign-extended.
- Any other opcode: `illegal`=1, `regwrite`=0, no hazard check. The instruction still issues.
- `readreg2` is 0 when the instruction does not read rt.
- `regwrite` is forced to 0 when the destination is register 0.
- Scoreboard is `busy[31:0]`. Bit 0 is hardwired to 0.
- Effective busy for the hazard check is `busy` with `wb_reg` cleared when `wb_valid`=1, i.e. a same-cycle release is visible.
- Hazard exists when any used source is effectively busy, or the destination is effectively busy.
- Issue occurs on `out_valid && out_ready`. On issue with `regwrite`=1, set `busy[writereg]`.
- `wb_valid` clears `busy[wb_reg]` at the clock edge.
- If issue sets and writeback clears the same register in one cycle, set wins.

## Timing
- Reset (`clr`=1 at an edge): `out_valid`=0, stage register empty, `busy`=0, all decoded outputs 0, `illegal`=0.
- `in_ready`=0 while `clr`=1.
- `clr` mid-operation discards the held instruction and all pending entries.
- `in_ready` = !full || issue in this cycle. Back-to-back throughput is 1 instruction/cycle.
- Latency: an instruction accepted at edge N presents `out_valid`=1 in cycle N+1 if there is no hazard.
- `out_valid` = full && !hazard. It is evaluated combinationally each cycle against the current `busy` and writeback.
- Decoded outputs are stable while full and not issued, and may depend only on the stage register.
- Not-issued is the case whether the cause is a hazard stall or `out_ready`=0.
- Upstream must hold `instr` stable while `in_valid` && !`in_ready`.

## Structure
- Shared package `decode_pkg`: opcode constants (`OP_RTYPE`, `OP_ADDI`, `OP_ANDI`, `OP_ORI`, `OP_LW`, `OP_SW`, `OP_BEQ`) and an enum `src_use_t` (NONE, RS, RS_RT).
- Sub-module `reg_scoreboard`, which owns:
  - the `busy` vector, with set/clear priority;
  - bit 0 forced to 0;
  - the combinational `is_busy(rs, rt, rd, uses)` query with wb bypass.
- The top level holds the stage register, the handshake and the pure combinational decode.

## Test plan
- **Reset:** `clr`=1 for 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=0, `busy`=0. `in_ready`=1 in the first cycle after `clr` drops.
- **R-type decode:** `instr`=0x014B4820 (add $9,$10,$11) → next cycle `readreg1`=10, `readreg2`=11, `writereg`=9, `regwrite`=1, `out_valid`=1.
- **Sign and zero extension:**
  - addi 0x2128FFFF → `imm_ext`=0xFFFFFFFF, `writereg`=8.
  - ori 0x3528FFFF → `imm_ext`=0x0000FFFF.
- **RAW stall and release:**
  - Issue lw $8 (0x8C080004), then add $9,$8,$8 → `out_valid` stays 0 and `in_ready`=0.
  - Pulse `wb_valid`=1, `wb_reg`=8 → the add issues in that same cycle.
- **Simultaneous set/clear:** issue addi $5 while `wb_valid`=1, `wb_reg`=5 → `busy[5]`=1 afterward.
- **$zero and illegal:**
  - add $0,$1,$2 → `regwrite`=0, no stall on later readers of $0.
  - opcode 0x3F → `illegal`=1, `regwrite`=0, issues without a stall.
